// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with enable, prescaled stepping, parallel load,
// wrap/saturate limit handling, sticky overflow and a cascade carry (tc).
// Stages chain by feeding tc of one stage into en of the next (PRESCALE=1).
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Prescaler is at least one bit wide so PRESCALE=1 still elaborates cleanly;
  // in that case it is pinned at 0 and every enabled cycle is a step.
  localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_MAX  = PW'(PRESCALE - 1);
  // Top of the count range; for MODULUS=2**WIDTH this is all ones, so a
  // load value can never exceed it and no clamp is applied.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic             step_due;
  logic             at_max;
  logic             at_zero;

  assign step_due = (ps_q == PS_MAX);
  assign at_max   = (count_q == MAX_CNT);
  assign at_zero  = (count_q == '0);

  // Next-state: clr > load > en; rst is applied in the register block.
  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    if (clr) begin
      count_d = '0;
      ps_d    = '0;
    end else if (load) begin
      count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
      ps_d    = '0;
    end else if (en) begin
      if (step_due) begin
        ps_d = '0;
        if (up_dn) begin
          if (!at_max) begin
            count_d = count_q + WIDTH'(1);
          end else if (sat_mode) begin
            ovf_set = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          if (!at_zero) begin
            count_d = count_q - WIDTH'(1);
          end else if (sat_mode) begin
            ovf_set = 1'b1;
          end else begin
            count_d = MAX_CNT;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
    // A new overflow beats a simultaneous clear request.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // All state in one register block with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ps_q    <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Carry out is suppressed whenever a higher-priority control owns the cycle.
  always_comb begin
    tc = en & step_due & (up_dn ? at_max : at_zero) & ~rst & ~clr & ~load;
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: M=16 free run, M=10 down/load/saturate,
// P=4 prescale, control priority and a two-digit decimal cascade.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, load, en, up_dn, sat_mode, ovf_clr;
  logic [3:0] load_val;

  logic [3:0] a_count, b_count, p_count, lo_count, hi_count;
  logic       a_tc, b_tc, p_tc, lo_tc, hi_tc;
  logic       a_wrap, b_wrap, p_wrap, lo_wrap, hi_wrap;
  logic       a_ovf, b_ovf, p_ovf, lo_ovf, hi_ovf;

  logic       c_clr, c_load, c_en;
  logic [3:0] c_load_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_m16 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
    .count(a_count), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
    .count(b_count), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
    .count(p_count), .tc(p_tc), .wrap(p_wrap), .ovf(p_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_lo (
    .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_load_val), .en(c_en),
    .up_dn(1'b1), .sat_mode(1'b0), .ovf_clr(1'b0),
    .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_hi (
    .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_load_val), .en(lo_tc),
    .up_dn(1'b1), .sat_mode(1'b0), .ovf_clr(1'b0),
    .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_down[6] = '{3, 2, 1, 0, 9, 8};
  logic pat_en[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0;
    up_dn = 1'b1; sat_mode = 1'b0; ovf_clr = 1'b0;
    c_clr = 1'b0; c_load = 1'b0; c_load_val = 4'd0; c_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_wrap",  32'(a_wrap), 0);
    chk("rst_ovf",   32'(a_ovf), 0);
    chk("rst_b",     32'(b_count), 0);

    // 1: free-running up count through the 15 -> 0 wrap
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk("t1_count", 32'(a_count), 32'(i % 16));
      chk("t1_tc",    32'(a_tc),    32'((i % 16) == 15));
      chk("t1_wrap",  32'(a_wrap),  32'(i == 16));
      tick();
    end

    // 2: M=10 down from 3, wrap 0 -> 9, then clamped load
    en = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_count", 32'(b_count), 32'(exp_down[i]));
      chk("t2_wrap",  32'(b_wrap),  32'(i == 4));
      chk("t2_tc",    32'(b_tc),    32'(exp_down[i] == 0));
      tick();
    end
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    chk("t2_clamp", 32'(b_count), 9);

    // 3: saturate at 9 going up, ovf sticky and its clear
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b1;
    #1;
    chk("t3_tc", 32'(b_tc), 1);
    tick();
    chk("t3_hold",  32'(b_count), 9);
    chk("t3_ovf",   32'(b_ovf), 1);
    chk("t3_nowrap", 32'(b_wrap), 0);
    en = 1'b0; ovf_clr = 1'b1;
    tick();
    chk("t3_ovfclr", 32'(b_ovf), 0);
    en = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("t3_setwins", 32'(b_ovf), 1);
    chk("t3_hold2",   32'(b_count), 9);
    en = 1'b0; ovf_clr = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_count", 32'(b_count), 0);
    chk("t3_clr_keeps_ovf", 32'(b_ovf), 1);
    sat_mode = 1'b0;

    // 4: P=4, en pattern 1,1,0,1,1 from count 9 -> single wrap step on 4th enabled cycle
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en = pat_en[i];
      #1;
      chk("t4_tc", 32'(p_tc), 32'(i == 4));
      tick();
      chk("t4_count", 32'(p_count), (i == 4) ? 0 : 9);
    end
    chk("t4_wrap", 32'(p_wrap), 1);
    en = 1'b0;

    // 5: priority
    rst = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    rst = 1'b0;
    chk("t5_rst_load", 32'(b_count), 0);
    load_val = 4'd7;
    tick();
    chk("t5_load7", 32'(b_count), 7);
    clr = 1'b1; load_val = 4'd5;
    tick();
    clr = 1'b0;
    chk("t5_clr_load", 32'(b_count), 0);
    load_val = 4'd9;
    tick();
    load_val = 4'd4; en = 1'b1; up_dn = 1'b1;
    #1;
    chk("t5_tc_forced", 32'(b_tc), 0);
    tick();
    load = 1'b0; en = 1'b0;
    chk("t5_load_en", 32'(b_count), 4);
    chk("t5_no_wrap", 32'(b_wrap), 0);

    // 6: two-digit decimal cascade 99 -> 00, then reset mid-run
    c_load = 1'b1; c_load_val = 4'd9;
    tick();
    c_load = 1'b0; c_en = 1'b1;
    #1;
    chk("t6_lo_tc", 32'(lo_tc), 1);
    chk("t6_hi_tc", 32'(hi_tc), 1);
    tick();
    chk("t6_lo0",   32'(lo_count), 0);
    chk("t6_hi0",   32'(hi_count), 0);
    chk("t6_lo_wrap", 32'(lo_wrap), 1);
    chk("t6_hi_wrap", 32'(hi_wrap), 1);
    for (int k = 0; k < 11; k++) tick();
    chk("t6_lo11", 32'(lo_count), 1);
    chk("t6_hi11", 32'(hi_count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_lo", 32'(lo_count), 0);
    chk("t6_rst_hi", 32'(hi_count), 0);
    c_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
